mean_removal_scheduler: RTL and testbench
=========================================

MEAN_REMOVAL_SCHEDULER -- requirements
Module: mean_removal_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of requesting channels (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT-state cycles before the block abandons a transaction.
REQ-003 The block SHALL have port clock, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port CE, input, 4 bits, meaning a per-channel one-cycle sample strobe.
REQ-006 The block SHALL have port data_in, input, 64 bits, meaning channel i's unsigned 16-bit sample at bits [16i+15:16i].
REQ-007 The block SHALL have port eng_data, output, 16 bits, meaning the sample presented to the shared mean-removal engine.
REQ-008 The block SHALL have port eng_ce, output, 1 bit, meaning the engine sample strobe.
REQ-009 The block SHALL have port eng_chan, output, 2 bits, meaning the engine RAM bank select (upper address bits).
REQ-010 The block SHALL have port eng_data_out, input, signed 32 bits, meaning the engine result.
REQ-011 The block SHALL have port eng_valid, input, 1 bit, meaning the engine result-valid pulse.
REQ-012 The block SHALL have port data_out, output, signed 32 bits, meaning the registered result.
REQ-013 The block SHALL have port chan_out, output, 2 bits, meaning the channel that owns data_out.
REQ-014 The block SHALL have port data_valid, output, 1 bit, meaning a one-cycle result strobe.
REQ-015 The block SHALL have port overrun, output, 4 bits, meaning sticky per-channel sample-lost flags.
REQ-016 The block SHALL have port timeout_err, output, 1 bit, meaning a one-cycle engine-timeout pulse.

Function
REQ-017 The block SHALL, on CE[i] high with pending[i]=0, capture data_in slice i into hold[i] and set pending[i] on the next edge.
REQ-018 The block SHALL, on CE[i] high with pending[i]=1 (and not being cleared that cycle), leave hold[i] unchanged and set overrun[i]; overrun bits SHALL clear only on reset.
REQ-019 The block SHALL implement a 4-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-020 The block SHALL, in IDLE with any pending bit set, select the first pending channel at or after rr_ptr (ascending, wrapping 3->0), latch it as cur_chan, and go to ISSUE; with none pending it SHALL stay in IDLE.
REQ-021 The block SHALL, in ISSUE, drive eng_ce=1 for exactly one cycle with eng_data=hold[cur_chan], eng_chan=cur_chan, clear pending[cur_chan], zero the timer, and go to WAIT.
REQ-022 The block SHALL, when CE[cur_chan] arrives in the ISSUE cycle, capture the new sample and leave pending set (set wins over clear), with no overrun.
REQ-023 The block SHALL, in WAIT with eng_valid=1, register data_out=eng_data_out and chan_out=cur_chan and go to DONE.
REQ-024 The block SHALL, in WAIT with eng_valid=0, increment the timer; when the timer equals TIMEOUT it SHALL pulse timeout_err for one cycle, set rr_ptr=cur_chan+1 mod 4, and return to IDLE without asserting data_valid.
REQ-025 The block SHALL, in DONE, assert data_valid for exactly one cycle, set rr_ptr=cur_chan+1 mod 4, and return to IDLE.
REQ-026 The block SHALL ignore eng_valid outside WAIT.
REQ-027 The block SHALL hold eng_ce=0 outside ISSUE, and SHALL hold eng_data and eng_chan stable from ISSUE until leaving WAIT.
REQ-028 The block SHALL produce data_valid exactly one cycle after eng_valid is sampled in WAIT, and SHALL hold data_out and chan_out until the next DONE.
REQ-029 The block SHALL keep at most one engine transaction outstanding, with minimum spacing of eng_ce pulses of 4 cycles (ISSUE, WAIT, DONE, IDLE).

Reset
REQ-030 The block SHALL, on reset, force state=IDLE, pending=0, hold=0, rr_ptr=0, timer=0, eng_ce=0, eng_data=0, eng_chan=0, data_out=0, chan_out=0, data_valid=0, overrun=0, and timeout_err=0.
REQ-031 The block SHALL treat reset asserted mid-transaction as abandoning that transaction, emit no data_valid, and ignore any late eng_valid.
REQ-032 The block SHALL have reset take priority over CE capture in the same cycle.

Verification
REQ-033 The bench SHALL cover: CE=4'b0001 with slice0=100, engine model returning 3 cycles after eng_ce with result 40 -> eng_chan=0, data_out=40, chan_out=0, one data_valid pulse.
REQ-034 The bench SHALL cover: CE=4'b1111 in one cycle -> eng_chan order 0,1,2,3, four data_valid pulses, no overrun.
REQ-035 The bench SHALL cover: rr_ptr=2 after serving ch1, then ch0 and ch3 pending together -> ch3 served before ch0.
REQ-036 The bench SHALL cover: CE[1] pulsed twice while pending[1]=1 (second pulse with data 7) -> overrun=4'b0010, and the first sample is issued rather than 7.
REQ-037 The bench SHALL cover: engine never asserts eng_valid -> timeout_err pulses 16 cycles after ISSUE, no data_valid, and the next pending channel is issued.
REQ-038 The bench SHALL cover: reset asserted in WAIT, with eng_valid arriving 1 cycle after reset is released -> no data_valid, all outputs 0, and state=IDLE.

Source files
------------

// File: rtl/mean_removal_scheduler_if.sv
// ----------------------------------------------------------------------------
// mean_removal_scheduler_if
// Bundles the sample inputs, the shared-engine handshake and the result
// outputs of mean_removal_scheduler.
//   slave  : scheduler view (samples and engine results in, everything else out)
//   master : environment view (drives samples and engine results)
// Signals:
//   CE[N_CH]         per-channel one-cycle sample strobe
//   data_in[16*N_CH] channel i sample at [16i+15:16i]
//   eng_data/eng_ce/eng_chan       request to the mean-removal engine
//   eng_data_out/eng_valid         engine result and its valid pulse
//   data_out/chan_out/data_valid   registered result, owner, one-cycle strobe
//   overrun[N_CH]    sticky sample-lost flags
//   timeout_err      one-cycle engine-timeout pulse
// ----------------------------------------------------------------------------
interface mean_removal_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]      CE;
  logic [16*N_CH-1:0]   data_in;
  logic [15:0]          eng_data;
  logic                 eng_ce;
  logic [CH_W-1:0]      eng_chan;
  logic signed [31:0]   eng_data_out;
  logic                 eng_valid;
  logic signed [31:0]   data_out;
  logic [CH_W-1:0]      chan_out;
  logic                 data_valid;
  logic [N_CH-1:0]      overrun;
  logic                 timeout_err;

  modport slave (
    input  CE, data_in, eng_data_out, eng_valid,
    output eng_data, eng_ce, eng_chan, data_out, chan_out, data_valid,
           overrun, timeout_err
  );

  modport master (
    output CE, data_in, eng_data_out, eng_valid,
    input  eng_data, eng_ce, eng_chan, data_out, chan_out, data_valid,
           overrun, timeout_err
  );
endinterface

// File: rtl/mean_removal_scheduler.sv
// ----------------------------------------------------------------------------
// mean_removal_scheduler
// Time-shares one mean-removal engine between N_CH sample channels.
// Each channel has a one-entry hold register; pending channels are served
// round-robin, one engine transaction at a time, with a timeout that abandons
// a transaction whose result never arrives.
// Ports:
//   clock : single clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : mean_removal_scheduler_if.slave (samples, engine handshake, results)
// ----------------------------------------------------------------------------
module mean_removal_scheduler #(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  mean_removal_scheduler_if.slave   bus
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int TMR_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [N_CH-1:0]     r_pending;
  logic [N_CH-1:0]     r_overrun;
  logic [15:0]         r_hold [N_CH];
  logic [15:0]         w_slice [N_CH];
  logic [N_CH-1:0]     w_clr;
  logic [N_CH-1:0]     w_cap;
  logic [N_CH-1:0]     w_ovr;

  logic [CH_W-1:0]     r_rr_ptr;
  logic [CH_W-1:0]     r_cur_chan;
  logic [CH_W-1:0]     w_sel;
  logic                w_any;

  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timer_inc;
  logic                w_tmo;

  logic                r_eng_ce;
  logic [15:0]         r_eng_data;
  logic [CH_W-1:0]     r_eng_chan;
  logic signed [31:0]  r_data_out;
  logic [CH_W-1:0]     r_chan_out;
  logic                r_data_valid;
  logic                r_timeout_err;

  // --------------------------------------------------------------------------
  // Per-channel capture decode. A strobe on the channel being issued this
  // cycle is accepted: the new sample replaces the one just handed to the
  // engine and pending stays set, so nothing is counted as lost.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_slice[gi] = bus.data_in[16*gi +: 16];
      assign w_clr[gi]   = (r_state == ST_ISSUE) && (r_cur_chan == CH_W'(gi));
      assign w_cap[gi]   = bus.CE[gi] && (!r_pending[gi] || w_clr[gi]);
      assign w_ovr[gi]   = bus.CE[gi] && r_pending[gi] && !w_clr[gi];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: first pending channel at or after r_rr_ptr. Scanning
  // offsets from far to near lets the nearest pending channel win.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel = r_rr_ptr;
    w_any = |r_pending;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_pending[r_rr_ptr + CH_W'(k)]) begin
        w_sel = r_rr_ptr + CH_W'(k);
      end
    end
  end

  // The timer counts WAIT cycles without a result; the transaction is
  // abandoned in the WAIT cycle whose incremented count reaches TIMEOUT, so
  // at most TIMEOUT WAIT cycles are spent. A result in that same cycle wins.
  assign w_timer_inc = r_timer + TMR_W'(1);
  assign w_tmo       = (r_state == ST_WAIT) && !bus.eng_valid &&
                       (w_timer_inc == TMR_W'(TIMEOUT));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.eng_valid) begin
          w_state_next = ST_DONE;
        end else if (w_tmo) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_overrun     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_hold[i] <= '0;
      end
      r_rr_ptr      <= '0;
      r_cur_chan    <= '0;
      r_timer       <= '0;
      r_eng_ce      <= 1'b0;
      r_eng_data    <= '0;
      r_eng_chan    <= '0;
      r_data_out    <= '0;
      r_chan_out    <= '0;
      r_data_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // Outputs are registered from the next state so they line up with it.
      r_eng_ce      <= (w_state_next == ST_ISSUE);
      r_data_valid  <= (w_state_next == ST_DONE);
      r_timeout_err <= w_tmo;

      for (int i = 0; i < N_CH; i++) begin
        if (w_cap[i]) begin
          r_hold[i]    <= w_slice[i];
          r_pending[i] <= 1'b1;
        end else if (w_clr[i]) begin
          r_pending[i] <= 1'b0;
        end
        if (w_ovr[i]) begin
          r_overrun[i] <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          // The selected hold register cannot change this cycle (its pending
          // bit is set), so the request is loaded here and stays stable
          // through ISSUE and WAIT.
          if (w_any) begin
            r_cur_chan <= w_sel;
            r_eng_chan <= w_sel;
            r_eng_data <= r_hold[w_sel];
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          if (bus.eng_valid) begin
            r_data_out <= bus.eng_data_out;
            r_chan_out <= r_cur_chan;
          end else begin
            r_timer <= w_timer_inc;
            if (w_tmo) begin
              r_rr_ptr <= r_cur_chan + CH_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_rr_ptr <= r_cur_chan + CH_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.eng_ce      = r_eng_ce;
  assign bus.eng_data    = r_eng_data;
  assign bus.eng_chan    = r_eng_chan;
  assign bus.data_out    = r_data_out;
  assign bus.chan_out    = r_chan_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mean_removal_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mean_removal_scheduler
// Directed stimulus with a scoreboard: each scenario pushes the expected
// engine requests and results into queues; a monitor pops and compares on
// every eng_ce and data_valid. The engine model returns (sample - 60) after
// a programmable latency and can silently drop requests.
// ----------------------------------------------------------------------------
module tb_mean_removal_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mean_removal_scheduler_if #(.N_CH(4)) bus ();

  mean_removal_scheduler #(.N_CH(4), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] data;
  } iss_t;

  typedef struct {
    logic [1:0]         chan;
    logic signed [31:0] val;
  } res_t;

  iss_t iss_q[$];
  res_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eng_lat  = 3;
  int drop_n   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_iss(input logic [1:0] c, input logic [15:0] d);
    iss_t e;
    e.chan = c;
    e.data = d;
    iss_q.push_back(e);
  endtask

  task automatic push_res(input logic [1:0] c, input int v);
    res_t e;
    e.chan = c;
    e.val  = v;
    res_q.push_back(e);
  endtask

  // Engine model
  initial begin
    logic [15:0] d;
    int r;
    forever begin
      @(negedge clock);
      if (bus.eng_ce === 1'b1) begin
        if (drop_n > 0) begin
          drop_n--;
        end else begin
          d = bus.eng_data;
          repeat (eng_lat) @(negedge clock);
          r = int'(d) - 60;
          bus.eng_data_out = r;
          bus.eng_valid    = 1'b1;
          @(negedge clock);
          bus.eng_valid    = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    iss_t ei;
    res_t er;
    forever begin
      @(negedge clock);
      if (bus.eng_ce === 1'b1) begin
        $display("issue   chan=%0d data=%0d t=%0t", bus.eng_chan, bus.eng_data, $time);
        if (iss_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got chan=%0d, expected no request", bus.eng_chan);
        end else begin
          ei = iss_q.pop_front();
          check("issue_chan", longint'(bus.eng_chan), longint'(ei.chan));
          check("issue_data", longint'(bus.eng_data), longint'(ei.data));
        end
      end
      if (bus.data_valid === 1'b1) begin
        $display("result  chan=%0d data=%0d t=%0t", bus.chan_out, bus.data_out, $time);
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got chan=%0d data=%0d, expected no result",
                   bus.chan_out, bus.data_out);
        end else begin
          er = res_q.pop_front();
          check("result_chan", longint'(bus.chan_out), longint'(er.chan));
          check("result_data", longint'(bus.data_out), longint'(er.val));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic pulse_ce(input logic [3:0] m, input logic [63:0] d);
    bus.CE      = m;
    bus.data_in = d;
    tick(1);
    bus.CE      = 4'b0000;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((iss_q.size() != 0 || res_q.size() != 0) && k < 300) begin
      tick(1);
      k++;
    end
    check({name, "_drain"}, longint'(iss_q.size() + res_q.size()), 0);
    iss_q.delete();
    res_q.delete();
    tick(4);
  endtask

  task automatic wait_issue(input string name);
    int k;
    bit ok;
    k  = 0;
    ok = 1'b0;
    while (k < 100 && !ok) begin
      tick(1);
      if (bus.eng_ce === 1'b1) ok = 1'b1;
      k++;
    end
    check({name, "_issue_seen"}, longint'(ok), 1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_eng_ce"},      longint'(bus.eng_ce), 0);
    check({name, "_eng_data"},    longint'(bus.eng_data), 0);
    check({name, "_eng_chan"},    longint'(bus.eng_chan), 0);
    check({name, "_data_out"},    longint'(bus.data_out), 0);
    check({name, "_chan_out"},    longint'(bus.chan_out), 0);
    check({name, "_data_valid"},  longint'(bus.data_valid), 0);
    check({name, "_overrun"},     longint'(bus.overrun), 0);
    check({name, "_timeout_err"}, longint'(bus.timeout_err), 0);
  endtask

  initial begin
    int t0;
    int k;
    bit seen;

    bus.CE           = 4'b0000;
    bus.data_in      = '0;
    bus.eng_data_out = '0;
    bus.eng_valid    = 1'b0;

    // Reset state
    do_reset();
    check_zero("reset");

    // Single channel: 100 -> engine result 40
    push_iss(2'd0, 16'd100);
    push_res(2'd0, 40);
    pulse_ce(4'b0001, {16'd0, 16'd0, 16'd0, 16'd100});
    wait_drain("single");

    // All four channels in one cycle: served 0,1,2,3
    do_reset();
    push_iss(2'd0, 16'd200); push_res(2'd0, 140);
    push_iss(2'd1, 16'd300); push_res(2'd1, 240);
    push_iss(2'd2, 16'd400); push_res(2'd2, 340);
    push_iss(2'd3, 16'd500); push_res(2'd3, 440);
    pulse_ce(4'b1111, {16'd500, 16'd400, 16'd300, 16'd200});
    wait_drain("all4");
    check("all4_overrun", longint'(bus.overrun), 0);

    // Round robin: after ch1, pointer is 2, so ch3 precedes ch0
    do_reset();
    push_iss(2'd1, 16'd50);
    push_res(2'd1, -10);
    pulse_ce(4'b0010, {16'd0, 16'd0, 16'd50, 16'd0});
    wait_drain("rr_ch1");
    push_iss(2'd3, 16'd30); push_res(2'd3, -30);
    push_iss(2'd0, 16'd10); push_res(2'd0, -50);
    pulse_ce(4'b1001, {16'd30, 16'd0, 16'd0, 16'd10});
    wait_drain("rr_order");

    // Overrun: second strobe on ch1 while still pending is dropped
    do_reset();
    push_iss(2'd1, 16'd70);
    push_res(2'd1, 10);
    pulse_ce(4'b0010, {16'd0, 16'd0, 16'd70, 16'd0});
    pulse_ce(4'b0010, {16'd0, 16'd0, 16'd7, 16'd0});
    check("overrun_set", longint'(bus.overrun), 2);
    wait_drain("overrun");
    check("overrun_sticky", longint'(bus.overrun), 2);

    // Timeout: engine ignores ch0, ch2 is issued afterwards
    do_reset();
    drop_n = 1;
    push_iss(2'd0, 16'd100);
    push_iss(2'd2, 16'd90);
    push_res(2'd2, 30);
    pulse_ce(4'b0101, {16'd0, 16'd90, 16'd0, 16'd100});
    wait_issue("tmo");
    t0   = cyc;
    k    = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      tick(1);
      if (bus.timeout_err === 1'b1) seen = 1'b1;
      k++;
    end
    check("timeout_latency", longint'(cyc - t0), 16);
    tick(1);
    check("timeout_one_cycle", longint'(bus.timeout_err), 0);
    wait_drain("tmo");

    // Reset during WAIT, late engine result must be ignored
    do_reset();
    eng_lat = 4;
    push_iss(2'd0, 16'd100);
    pulse_ce(4'b0001, {16'd0, 16'd0, 16'd0, 16'd100});
    wait_issue("rstwait");
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("rstwait_no_valid", longint'(bus.data_valid), 0);
    end
    check_zero("rstwait");
    eng_lat = 3;
    wait_drain("rstwait");

    // Strobe during ISSUE of the same channel: captured, no overrun
    do_reset();
    push_iss(2'd0, 16'd100); push_res(2'd0, 40);
    push_iss(2'd0, 16'd120); push_res(2'd0, 60);
    pulse_ce(4'b0001, {16'd0, 16'd0, 16'd0, 16'd100});
    wait_issue("setwins");
    pulse_ce(4'b0001, {16'd0, 16'd0, 16'd0, 16'd120});
    wait_drain("setwins");
    check("setwins_overrun", longint'(bus.overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
